task_dispatcher: RTL and testbench
==================================

Name: task_dispatcher

Overview:
- Central work scheduler and the responder side of each processor core's new-PC request handshake.
- Sinks every core's queue writes (queue_wen/queue_number); each write enqueues one pending task on the numbered queue.
- Whenever a core raises request_new_pc and any queue holds a task, the block grants that core the queue's entry PC via a one-cycle set_pc/new_pc pulse.
- Sits between the processor array and the per-queue entry-PC table, which the host loads through a config port.

Parameters:
- NUM_CORES, 4, number of processor cores served; must be 1..16.
- NUM_QUEUES, 16, number of task queues; queue numbers are 4 bits wide.
- CNT_W, 8, width of each queue's pending-task counter; saturates at 2^CNT_W-1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- core_request_new_pc  in  NUM_CORES  bit i is core i's request_new_pc.
- core_set_pc  out  NUM_CORES  one-hot grant pulse; bit i drives core i's set_pc.
- core_new_pc  out  16  entry PC; shared by all cores and valid whenever any core_set_pc bit is high.
- core_queue_wen  in  NUM_CORES  bit i is core i's queue_wen.
- core_queue_number  in  4*NUM_CORES  bits [4i+3:4i] are core i's queue_number.
- cfg_pc_wen  in  1  writes cfg_pc into the entry-PC table at index cfg_queue.
- cfg_push  in  1  enqueues one task on cfg_queue (host seeding).
- cfg_queue  in  4  config queue index.
- cfg_pc  in  16  entry PC value to write.
- overflow  out  1  sticky flag: an enqueue was lost to counter saturation.
- idle  out  1  all counters are zero, every core is requesting, and no grant is in flight.

Behaviour:
- Reset (synchronous, checked before everything else):
  - clears all counters and entry PCs to 0;
  - clears core_set_pc, core_new_pc, overflow and the round-robin pointer to 0;
  - the FSM goes to SCAN;
  - reset mid-grant kills the pulse on the next edge.
- Enqueue, every cycle:
  - delta[q] = number of cores i with core_queue_wen[i]=1 and queue number q, plus cfg_push when cfg_queue=q.
  - count[q] <= min(count[q] + delta[q] - dequeue[q], max); the sum is computed at CNT_W+3 bits.
  - If saturation truncates any increment, overflow <= 1. It stays 1 until rst.
- Queue numbers >= NUM_QUEUES are ignored: no count change, no overflow.
- Same-cycle enqueue and dequeue on one queue net out. An enqueue becomes dispatchable only from the next cycle, because selection uses registered counts.
- Selection uses registered state only:
  - eligible[i] = core_request_new_pc[i] & ~granted_last[i];
  - queue choice: lowest-index q with count[q] != 0;
  - core choice: round-robin among eligible cores, starting at rr_ptr.
- FSM states:
  - SCAN: if any core and any queue are eligible, register core_set_pc = onehot(i) and core_new_pc = entry_pc[q]. Decrement count[q] in the same edge, set rr_ptr <= i+1 (mod NUM_CORES), set granted_last <= onehot(i), and go to GRANT. Otherwise outputs stay 0 and the FSM stays in SCAN.
  - GRANT: the pulse is visible for exactly one cycle. On the next edge, clear core_set_pc and go to HOLD. granted_last stays set because the core's request_new_pc drops one cycle after it samples set_pc.
  - HOLD: clear granted_last and return to SCAN.
- Throughput is one grant per 3 cycles.
- Grant latency is 1 cycle: a request plus a nonzero count present at edge T produce core_set_pc high from T to T+1.
- core_new_pc holds its last value when no pulse is active, so it can be checked against a golden model.
- A cfg_pc_wen in the same cycle as a grant from that queue: the grant uses the old entry PC; the new value is visible from the next cycle.
- A request that drops before it is granted is simply not eligible; no grant is issued.

Optional Feature:
- Macro DISPATCH_STATS_EN.
- Defined: adds output dispatch_count (32 bits), which increments on each grant, wraps at 2^32 and resets to 0. Also adds output max_pending (CNT_W bits), the high-water mark of any queue's count, sticky until rst.
- Undefined: neither port exists and no logic is generated.

Decomposition:
- Shared package gpu_pkg holds: PC_W=16, QNUM_W=4, INSTR_W=32, opcode constants (the queue-write opcodes 14 and 15, new-PC request opcode 16), and the FSM state enum (SCAN, GRANT, HOLD).
- One sub-module: rr_arbiter, a parameterised round-robin one-hot picker with a pointer input. It is reusable for future memory-port arbitration.

Test Plan:
- Load entry_pc[3]=0x0040, cfg_push queue 3 once, core 0 requesting -> core_set_pc=0001 for exactly 1 cycle with core_new_pc=0x0040, count[3]=0, no second grant.
- Cores 0-3 all requesting, 4 pushes to queue 1 -> grants in order cores 0,1,2,3, each 3 cycles apart, all with entry_pc[1]; idle=1 afterwards.
- Cores 1 and 2 both write queue 5 in one cycle while count[5]=254 (CNT_W=8) -> count[5]=255, overflow=1.
- Counts in queues 2 and 7, one request -> queue 2 served first; queue 7 on the next grant.
- Assert rst in the GRANT cycle -> next cycle core_set_pc=0, all counts 0, overflow=0, rr_ptr=0.
- DISPATCH_STATS_EN build, 5 grants -> dispatch_count=5; max_pending equals the peak count reached.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared GPU definitions: datapath widths, instruction opcodes and the dispatcher FSM states.
package gpu_pkg;

    localparam int PC_W    = 16;
    localparam int QNUM_W  = 4;
    localparam int INSTR_W = 32;

    // Queue-write opcodes and the new-PC request opcode issued by the cores.
    localparam int OP_QUEUE_WR_A   = 14;
    localparam int OP_QUEUE_WR_B   = 15;
    localparam int OP_REQ_NEW_PC   = 16;

    typedef enum logic [1:0] {
        SCAN  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } disp_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot picker: first requester found scanning upward from ptr, wrapping at N.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] grant_idx,
    output logic             valid
);

    always_comb begin
        int c;
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        c         = 0;
        for (int k = 0; k < N; k++) begin
            c = (int'(ptr) + k) % N;
            if (!valid && req[c]) begin
                valid     = 1'b1;
                grant[c]  = 1'b1;
                grant_idx = PTR_W'(c);
            end
        end
    end

endmodule

// File: rtl/task_dispatcher.sv
// Per-queue pending-task counters plus a SCAN/GRANT/HOLD grant engine handing entry PCs to cores.
// Defining DISPATCH_STATS_EN adds the dispatch_count and max_pending statistics outputs.
module task_dispatcher
    import gpu_pkg::*;
#(
    parameter int NUM_CORES  = 4,
    parameter int NUM_QUEUES = 16,
    parameter int CNT_W      = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CORES-1:0]        core_request_new_pc,
    output logic [NUM_CORES-1:0]        core_set_pc,
    output logic [PC_W-1:0]             core_new_pc,
    input  logic [NUM_CORES-1:0]        core_queue_wen,
    input  logic [QNUM_W*NUM_CORES-1:0] core_queue_number,
    input  logic                        cfg_pc_wen,
    input  logic                        cfg_push,
    input  logic [QNUM_W-1:0]           cfg_queue,
    input  logic [PC_W-1:0]             cfg_pc,
    output logic                        overflow,
    output logic                        idle
`ifdef DISPATCH_STATS_EN
    ,
    output logic [31:0]                 dispatch_count,
    output logic [CNT_W-1:0]            max_pending
`endif
);

    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int SUM_W = CNT_W + 3;
    localparam logic [SUM_W-1:0] CNT_MAX = {3'b000, {CNT_W{1'b1}}};

    disp_state_t          state;
    logic [CNT_W-1:0]     count      [NUM_QUEUES];
    logic [CNT_W-1:0]     next_count [NUM_QUEUES];
    logic [PC_W-1:0]      entry_pc   [NUM_QUEUES];
    logic [NUM_CORES-1:0] granted_last;
    logic [NUM_CORES-1:0] eligible;
    logic [NUM_CORES-1:0] pick;
    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     pick_idx;
    logic                 pick_valid;
    logic                 q_found;
    logic [QNUM_W-1:0]    sel_q;
    logic                 take;
    logic                 sat_hit;

    assign eligible = core_request_new_pc & ~granted_last;

    rr_arbiter #(.N(NUM_CORES), .PTR_W(PTR_W)) u_arb (
        .req       (eligible),
        .ptr       (rr_ptr),
        .grant     (pick),
        .grant_idx (pick_idx),
        .valid     (pick_valid)
    );

    // Lowest-index non-empty queue wins; scanning downward leaves the lowest one last.
    always_comb begin
        q_found = 1'b0;
        sel_q   = '0;
        for (int q = NUM_QUEUES - 1; q >= 0; q--) begin
            if (count[q] != '0) begin
                q_found = 1'b1;
                sel_q   = QNUM_W'(q);
            end
        end
    end

    assign take = (state == SCAN) && q_found && pick_valid;
    assign idle = !q_found && (&core_request_new_pc) && (state == SCAN);

    // Enqueues and the dequeue net out in one wide sum before saturating.
    always_comb begin
        logic [SUM_W-1:0] sum;
        sat_hit = 1'b0;
        sum     = '0;
        for (int q = 0; q < NUM_QUEUES; q++) begin
            sum = SUM_W'(count[q]);
            for (int i = 0; i < NUM_CORES; i++) begin
                if (core_queue_wen[i] && core_queue_number[QNUM_W*i +: QNUM_W] == QNUM_W'(q))
                    sum = sum + SUM_W'(1);
            end
            if (cfg_push && cfg_queue == QNUM_W'(q))
                sum = sum + SUM_W'(1);
            if (take && sel_q == QNUM_W'(q))
                sum = sum - SUM_W'(1);
            if (sum > CNT_MAX) begin
                next_count[q] = {CNT_W{1'b1}};
                sat_hit       = 1'b1;
            end else begin
                next_count[q] = sum[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int q = 0; q < NUM_QUEUES; q++) begin
                count[q]    <= '0;
                entry_pc[q] <= '0;
            end
            core_set_pc  <= '0;
            core_new_pc  <= '0;
            overflow     <= 1'b0;
            rr_ptr       <= '0;
            granted_last <= '0;
            state        <= SCAN;
        end else begin
            for (int q = 0; q < NUM_QUEUES; q++)
                count[q] <= next_count[q];
            if (sat_hit)
                overflow <= 1'b1;
            if (cfg_pc_wen && int'(cfg_queue) < NUM_QUEUES)
                entry_pc[cfg_queue] <= cfg_pc;
            case (state)
                SCAN: begin
                    if (take) begin
                        core_set_pc  <= pick;
                        core_new_pc  <= entry_pc[sel_q];
                        granted_last <= pick;
                        rr_ptr       <= (pick_idx == PTR_W'(NUM_CORES - 1)) ? '0
                                                                             : pick_idx + PTR_W'(1);
                        state        <= GRANT;
                    end
                end
                GRANT: begin
                    core_set_pc <= '0;
                    state       <= HOLD;
                end
                HOLD: begin
                    // The granted core has dropped its request by now.
                    granted_last <= '0;
                    state        <= SCAN;
                end
                default: state <= SCAN;
            endcase
        end
    end

`ifdef DISPATCH_STATS_EN
    logic [CNT_W-1:0] peak;

    always_comb begin
        peak = max_pending;
        for (int q = 0; q < NUM_QUEUES; q++) begin
            if (next_count[q] > peak)
                peak = next_count[q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dispatch_count <= '0;
            max_pending    <= '0;
        end else begin
            if (take)
                dispatch_count <= dispatch_count + 32'd1;
            max_pending <= peak;
        end
    end
`endif

endmodule

// File: tb/tb_task_dispatcher.sv
// Self-checking bench for task_dispatcher: directed scenarios then random traffic against a queue-count model.
module tb_task_dispatcher;

    localparam int NC   = 4;
    localparam int NQ   = 16;
    localparam int CW   = 8;
    localparam int CMAX = 255;

    logic            clk = 1'b0;
    logic            rst;
    logic [NC-1:0]   req;
    logic [NC-1:0]   set_pc;
    logic [15:0]     new_pc;
    logic [NC-1:0]   wen;
    logic [4*NC-1:0] qnum;
    logic            cfg_pc_wen;
    logic            cfg_push;
    logic [3:0]      cfg_queue;
    logic [15:0]     cfg_pc;
    logic            overflow;
    logic            idle;
`ifdef DISPATCH_STATS_EN
    logic [31:0]     dcount;
    logic [CW-1:0]   maxp;
`endif

    task_dispatcher #(.NUM_CORES(NC), .NUM_QUEUES(NQ), .CNT_W(CW)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .core_request_new_pc (req),
        .core_set_pc         (set_pc),
        .core_new_pc         (new_pc),
        .core_queue_wen      (wen),
        .core_queue_number   (qnum),
        .cfg_pc_wen          (cfg_pc_wen),
        .cfg_push            (cfg_push),
        .cfg_queue           (cfg_queue),
        .cfg_pc              (cfg_pc),
        .overflow            (overflow),
        .idle                (idle)
`ifdef DISPATCH_STATS_EN
        ,
        .dispatch_count      (dcount),
        .max_pending         (maxp)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: pending tasks per queue, entry PCs, and the grant cadence.
    int            mcount [NQ];
    logic [15:0]   mpc    [NQ];
    int            busy;
    int            rr;
    logic [NC-1:0] exp_set;
    logic [15:0]   exp_pc;
    logic          exp_ovf;
    int            m_disp;
    int            m_peak;

    int            obs_core [$];
    logic [15:0]   obs_pc   [$];
    int            obs_cyc  [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int q = 0; q < NQ; q++) begin
            mcount[q] = 0;
            mpc[q]    = '0;
        end
        busy    = 0;
        rr      = 0;
        exp_set = '0;
        exp_pc  = '0;
        exp_ovf = 1'b0;
        m_disp  = 0;
        m_peak  = 0;
    endtask

    task automatic quiet_inputs();
        wen        = '0;
        qnum       = '0;
        cfg_pc_wen = 1'b0;
        cfg_push   = 1'b0;
        cfg_queue  = '0;
        cfg_pc     = '0;
    endtask

    task automatic clear_obs();
        obs_core.delete();
        obs_pc.delete();
        obs_cyc.delete();
    endtask

    // One clock: decide the model grant from pre-edge state, update on the edge, then check.
    task automatic cycle();
        int sel_q;
        int sel_c;
        int t;
        int delta [NQ];
        logic all_zero;
        sel_q = -1;
        sel_c = -1;
        for (int q = 0; q < NQ; q++)
            if (sel_q < 0 && mcount[q] != 0) sel_q = q;
        if (busy == 0 && sel_q >= 0)
            for (int k = 0; k < NC; k++)
                if (sel_c < 0 && req[(rr + k) % NC]) sel_c = (rr + k) % NC;
        @(posedge clk);
        cyc++;
        if (rst) begin
            m_reset();
        end else begin
            for (int q = 0; q < NQ; q++) delta[q] = 0;
            for (int i = 0; i < NC; i++)
                if (wen[i]) delta[qnum[4*i +: 4]]++;
            if (cfg_push) delta[cfg_queue]++;
            exp_set = '0;
            if (sel_c >= 0) begin
                exp_set[sel_c] = 1'b1;
                exp_pc         = mpc[sel_q];
                delta[sel_q]--;
                rr             = (sel_c + 1) % NC;
                busy           = 2;
                m_disp++;
            end else if (busy > 0) begin
                busy--;
            end
            for (int q = 0; q < NQ; q++) begin
                t = mcount[q] + delta[q];
                if (t > CMAX) begin
                    mcount[q] = CMAX;
                    exp_ovf   = 1'b1;
                end else begin
                    mcount[q] = t;
                end
                if (mcount[q] > m_peak) m_peak = mcount[q];
            end
            if (cfg_pc_wen) mpc[cfg_queue] = cfg_pc;
        end
        #1;
        all_zero = 1'b1;
        for (int q = 0; q < NQ; q++)
            if (mcount[q] != 0) all_zero = 1'b0;
        check("set_pc", 32'(set_pc), 32'(exp_set));
        check("new_pc", 32'(new_pc), 32'(exp_pc));
        check("overflow", 32'(overflow), 32'(exp_ovf));
        check("idle", 32'(idle), 32'(all_zero && (&req) && busy == 0));
        for (int q = 0; q < NQ; q++)
            check($sformatf("count[%0d]", q), 32'(dut.count[q]), 32'(mcount[q]));
`ifdef DISPATCH_STATS_EN
        check("dispatch_count", dcount, 32'(m_disp));
        check("max_pending", 32'(maxp), 32'(m_peak));
`endif
        for (int i = 0; i < NC; i++)
            if (set_pc[i] === 1'b1) begin
                obs_core.push_back(i);
                obs_pc.push_back(new_pc);
                obs_cyc.push_back(cyc);
            end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        quiet_inputs();
        cycle();
        rst = 1'b0;
    endtask

    task automatic write_pc(input int q, input logic [15:0] pc);
        cfg_pc_wen = 1'b1;
        cfg_queue  = 4'(q);
        cfg_pc     = pc;
        cycle();
        cfg_pc_wen = 1'b0;
    endtask

    task automatic push(input int q);
        cfg_push  = 1'b1;
        cfg_queue = 4'(q);
        cycle();
        cfg_push  = 1'b0;
    endtask

    initial begin
        m_reset();
        req = '0;
        rst = 1'b1;
        quiet_inputs();
        cycle();
        cycle();
        rst = 1'b0;
        check("reset_rr_ptr", 32'(dut.rr_ptr), 32'd0);
        check("reset_set_pc", 32'(set_pc), 32'd0);

        // Single task on queue 3, core 0 requesting: one grant, entry PC 0x0040.
        write_pc(3, 16'h0040);
        push(3);
        clear_obs();
        req = 4'b0001;
        repeat (8) cycle();
        req = '0;
        check("s1_grants", obs_core.size(), 32'd1);
        if (obs_core.size() >= 1) begin
            check("s1_core", 32'(obs_core[0]), 32'd0);
            check("s1_pc", 32'(obs_pc[0]), 32'h0040);
        end
        check("s1_count3", 32'(dut.count[3]), 32'd0);

        // All cores requesting, four tasks on queue 1: grants 0,1,2,3 three cycles apart.
        do_reset();
        write_pc(1, 16'h1234);
        clear_obs();
        req = 4'b1111;
        for (int k = 0; k < 4; k++) push(1);
        repeat (14) cycle();
        check("s2_grants", obs_core.size(), 32'd4);
        if (obs_core.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                check("s2_core", 32'(obs_core[k]), 32'(k));
                check("s2_pc", 32'(obs_pc[k]), 32'h1234);
                if (k > 0) check("s2_spacing", 32'(obs_cyc[k] - obs_cyc[k-1]), 32'd3);
            end
        end
        check("s2_idle", 32'(idle), 32'd1);
        req = '0;

        // Saturation: queue 5 at 254, two cores write it in one cycle.
        do_reset();
        repeat (254) push(5);
        check("s3_count5_pre", 32'(dut.count[5]), 32'd254);
        check("s3_ovf_pre", 32'(overflow), 32'd0);
        wen  = 4'b0110;
        qnum = {4'd0, 4'd5, 4'd5, 4'd0};
        cycle();
        quiet_inputs();
        check("s3_count5", 32'(dut.count[5]), 32'd255);
        check("s3_ovf", 32'(overflow), 32'd1);

        // Reset during GRANT clears pulse, counts, overflow and pointer.
        req = 4'b1111;
        for (int k = 0; k < 10 && set_pc == '0; k++) cycle();
        check("s5_grant_seen", 32'(set_pc != '0), 32'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("s5_set_pc", 32'(set_pc), 32'd0);
        check("s5_count5", 32'(dut.count[5]), 32'd0);
        check("s5_ovf", 32'(overflow), 32'd0);
        check("s5_rr_ptr", 32'(dut.rr_ptr), 32'd0);
        req = '0;

        // Queues 2 and 7 pending: the lower queue is served first.
        do_reset();
        write_pc(2, 16'h0222);
        write_pc(7, 16'h0777);
        push(7);
        push(2);
        clear_obs();
        req = 4'b0001;
        repeat (10) cycle();
        req = '0;
        check("s4_grants", obs_core.size(), 32'd2);
        if (obs_pc.size() == 2) begin
            check("s4_first_pc", 32'(obs_pc[0]), 32'h0222);
            check("s4_second_pc", 32'(obs_pc[1]), 32'h0777);
        end

        // Random traffic against the model.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            req        = 4'($urandom_range(0, 15));
            wen        = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            qnum       = 16'($urandom);
            cfg_push   = ($urandom_range(0, 2) == 0);
            cfg_pc_wen = ($urandom_range(0, 4) == 0);
            cfg_queue  = 4'($urandom_range(0, 15));
            cfg_pc     = 16'($urandom);
            rst        = ($urandom_range(0, 199) == 0);
            cycle();
        end
        rst = 1'b0;
        quiet_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
